// File: rtl/iir_coef_ctrl_if.sv
// Configuration bus between the register port and the IIR coefficient controller.
// The requester (master) writes coefficients and pulses commit; the controller (slave) answers.
interface iir_coef_ctrl_if #(
  parameter int COEF_W = 16
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [2:0]        cfg_addr;
  logic [COEF_W-1:0] cfg_data;
  logic              cfg_commit;
  logic              cfg_err;

  modport master (
    output cfg_valid, cfg_addr, cfg_data, cfg_commit,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_addr, cfg_data, cfg_commit,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/iir_coef_ctrl.sv
// Coefficient shadow/active banks for the biquad notch filter, plus the commit/flush/settle
// sequencer that holds the filter in reset and masks sample validity while its history refills.
module iir_coef_ctrl #(
  parameter int COEF_W       = 16,
  parameter int FLUSH_CYCLES = 4,
  parameter int PIPE_LAT     = 3
) (
  input  logic              clk,
  input  logic              rst,
  iir_coef_ctrl_if.slave    cfg,
  input  logic              in_valid_i,
  output logic              out_valid_o,
  output logic              busy_o,
  output logic              filt_rst_n_o,
  output logic [COEF_W-1:0] b0_o,
  output logic [COEF_W-1:0] b1_o,
  output logic [COEF_W-1:0] b2_o,
  output logic [COEF_W-1:0] a1_o,
  output logic [COEF_W-1:0] a2_o
);

  typedef enum logic [1:0] {IDLE, ARMED, FLUSH, SETTLE} state_e;

  // Bank index order matches cfg_addr: 0=B0, 1=B1, 2=B2, 3=A1, 4=A2.
  typedef logic [0:4][COEF_W-1:0] bank_t;

  localparam logic [COEF_W-1:0] B0_UNITY = COEF_W'(16384);
  localparam bank_t             BANK_RST = {B0_UNITY, {(4*COEF_W){1'b0}}};
  localparam int                CNT_MAX  = (FLUSH_CYCLES > PIPE_LAT) ? FLUSH_CYCLES : PIPE_LAT;
  localparam int                CNT_W    = $clog2(CNT_MAX + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  bank_t               shadow_q, shadow_d;
  bank_t               active_q, active_d;
  logic [PIPE_LAT-1:0] valid_q, valid_d;
  logic                filt_rst_n_q, filt_rst_n_d;
  logic                busy_q, busy_d;
  logic                cfg_ready_q, cfg_ready_d;
  logic                cfg_err_q, cfg_err_d;
  logic                accept, legal;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;

    accept = cfg.cfg_valid && cfg_ready_q;
    legal  = (cfg.cfg_addr <= 3'd4);

    // The write lands first so a same-cycle commit transfers the updated value.
    if (accept && legal) begin
      shadow_d[cfg.cfg_addr] = cfg.cfg_data;
    end

    unique case (state_q)
      IDLE: begin
        if (accept && legal) state_d = ARMED;
      end
      ARMED: begin
        if (cfg.cfg_commit) begin
          active_d = shadow_d;
          state_d  = FLUSH;
          cnt_d    = '0;
        end
      end
      FLUSH: begin
        if (cnt_q == CNT_W'(FLUSH_CYCLES - 1)) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SETTLE: begin
        if (cnt_q == CNT_W'(PIPE_LAT - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = FLUSH;
        cnt_d   = '0;
      end
    endcase

    filt_rst_n_d = (state_d != FLUSH);
    busy_d       = (state_d == FLUSH) || (state_d == SETTLE);
    cfg_ready_d  = (state_d == IDLE) || (state_d == ARMED);
    cfg_err_d    = accept && !legal;

    // A sample only advances when the filter is out of reset both now and next cycle,
    // so out_valid drops on the commit edge and nothing presented during flush survives.
    valid_d = '0;
    if (filt_rst_n_q && filt_rst_n_d) begin
      valid_d[0] = in_valid_i;
      for (int i = 1; i < PIPE_LAT; i++) valid_d[i] = valid_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the coefficient banks are reset too: the filter must see pass-through values after rst.
      state_q      <= FLUSH;
      cnt_q        <= '0;
      shadow_q     <= BANK_RST;
      active_q     <= BANK_RST;
      valid_q      <= '0;
      filt_rst_n_q <= 1'b0;
      busy_q       <= 1'b1;
      cfg_ready_q  <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      valid_q      <= valid_d;
      filt_rst_n_q <= filt_rst_n_d;
      busy_q       <= busy_d;
      cfg_ready_q  <= cfg_ready_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign cfg.cfg_ready = cfg_ready_q;
  assign cfg.cfg_err   = cfg_err_q;
  assign out_valid_o   = valid_q[PIPE_LAT-1];
  assign busy_o        = busy_q;
  assign filt_rst_n_o  = filt_rst_n_q;
  assign b0_o          = active_q[0];
  assign b1_o          = active_q[1];
  assign b2_o          = active_q[2];
  assign a1_o          = active_q[3];
  assign a2_o          = active_q[4];

endmodule

// File: tb/tb_iir_coef_ctrl.sv
// Directed bench for iir_coef_ctrl: a reference bank model pushes expected active banks on
// every commit; they are popped and compared when the DUT enters flush.
module tb_iir_coef_ctrl;

  localparam int FC = 4;
  localparam int PL = 3;

  typedef logic [0:4][15:0] bank_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b1;
  logic out_valid, busy, filt_rst_n;
  logic [15:0] b0, b1, b2, a1, a2;

  iir_coef_ctrl_if #(.COEF_W(16)) cfg_if ();

  iir_coef_ctrl #(.COEF_W(16), .FLUSH_CYCLES(FC), .PIPE_LAT(PL)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg          (cfg_if.slave),
    .in_valid_i   (in_valid),
    .out_valid_o  (out_valid),
    .busy_o       (busy),
    .filt_rst_n_o (filt_rst_n),
    .b0_o         (b0),
    .b1_o         (b1),
    .b2_o         (b2),
    .a1_o         (a1),
    .a2_o         (a2)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_errors = 0;
  bank_t shadow_m, active_m;
  bit    armed_m;
  bank_t exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    shadow_m    = '0;
    shadow_m[0] = 16'h4000;
    active_m    = shadow_m;
    armed_m     = 1'b0;
  endtask

  task automatic check_coefs(input string tag, input bank_t e);
    check({tag, "_b0"}, b0, e[0]);
    check({tag, "_b1"}, b1, e[1]);
    check({tag, "_b2"}, b2, e[2]);
    check({tag, "_a1"}, a1, e[3]);
    check({tag, "_a2"}, a2, e[4]);
  endtask

  // Pops the bank queued by the latest commit and compares it with the DUT outputs.
  task automatic check_bank(input string tag);
    bank_t e;
    check({tag, "_sb_nonempty"}, exp_q.size() > 0, 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_coefs(tag, e);
    end
  endtask

  task automatic model_commit();
    if (armed_m) begin
      active_m = shadow_m;
      armed_m  = 1'b0;
      exp_q.push_back(active_m);
    end
  endtask

  // Holds a write until accepted; returns the number of cycles spent stalled.
  task automatic do_write(input logic [2:0] a, input logic [15:0] d, input bit commit,
                          output int waited);
    waited = 0;
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_addr   = a;
    cfg_if.cfg_data   = d;
    cfg_if.cfg_commit = commit;
    while (!cfg_if.cfg_ready && waited < 50) begin
      tick();
      waited++;
    end
    check("wr_accept_timeout", waited < 50, 1);
    if (a <= 3'd4) begin
      shadow_m[a] = d;
      if (!armed_m) armed_m = 1'b1;
      else if (commit) model_commit();
    end else if (commit) begin
      model_commit();
    end
    tick();
    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_commit = 1'b0;
  endtask

  task automatic do_commit();
    cfg_if.cfg_commit = 1'b1;
    model_commit();
    tick();
    cfg_if.cfg_commit = 1'b0;
  endtask

  // Called in the first cycle after a commit edge; ends in the first IDLE cycle.
  task automatic flush_seq(input string tag);
    for (int k = 0; k <= FC + PL; k++) begin
      if (k == 0) check_bank(tag);
      check({tag, "_filt_rst_n"}, filt_rst_n, k >= FC);
      check({tag, "_busy"}, busy, k < FC + PL);
      check({tag, "_ready"}, cfg_if.cfg_ready, k >= FC + PL);
      check({tag, "_out_valid"}, out_valid, k >= FC + PL);
      if (k == FC + PL - 1) check_coefs({tag, "_hold"}, active_m);
      if (k < FC + PL) tick();
    end
  endtask

  // Called in the first cycle after the rst edge; ends in the first IDLE cycle.
  task automatic reset_seq(input string tag);
    for (int k = 0; k <= FC + PL; k++) begin
      if (k == 0) begin
        check_coefs({tag, "_coef"}, active_m);
        check({tag, "_err"}, cfg_if.cfg_err, 0);
      end
      check({tag, "_filt_rst_n"}, filt_rst_n, k >= FC);
      check({tag, "_busy"}, busy, k < FC + PL);
      check({tag, "_ready"}, cfg_if.cfg_ready, k >= FC + PL);
      check({tag, "_out_valid"}, out_valid, k >= FC + PL);
      if (k < FC + PL) tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_addr   = '0;
    cfg_if.cfg_data   = '0;
    cfg_if.cfg_commit = 1'b0;
    model_reset();

    // Power-on reset and default pass-through coefficients.
    tick();
    tick();
    rst = 1'b0;
    reset_seq("por");

    // Three coefficient writes, then one commit applies them together.
    do_write(3'd0, 16'h3A00, 1'b0, w);
    do_write(3'd1, 16'h8C40, 1'b0, w);
    do_write(3'd3, 16'h7000, 1'b0, w);
    check("pre_commit_b0", b0, 16'h4000);
    check("pre_commit_busy", busy, 0);
    do_commit();
    flush_seq("commit1");

    // A write held through flush/settle stalls until the first IDLE cycle.
    do_write(3'd1, 16'h8C40, 1'b0, w);
    do_commit();
    check_bank("commit2");
    do_write(3'd2, 16'h1234, 1'b0, w);
    check("stall_cycles", w, FC + PL);
    check("stall_b2_active", b2, 16'h0000);
    do_commit();
    flush_seq("commit3");

    // Illegal address: err pulse, nothing changes, following commit in IDLE ignored.
    do_write(3'd6, 16'h5555, 1'b0, w);
    check("illegal_err_pulse", cfg_if.cfg_err, 1);
    check("illegal_ready", cfg_if.cfg_ready, 1);
    tick();
    check("illegal_err_clear", cfg_if.cfg_err, 0);
    do_commit();
    for (int k = 0; k < 3; k++) begin
      check("idle_commit_no_flush", filt_rst_n, 1);
      check("idle_commit_not_busy", busy, 0);
      tick();
    end
    check_coefs("illegal_hold", active_m);

    // Write and commit in the same ARMED cycle.
    do_write(3'd2, 16'h1234, 1'b0, w);
    do_write(3'd4, 16'hC000, 1'b1, w);
    flush_seq("same_cycle");

    // Write plus commit in IDLE arms only; then reset on the second flush cycle.
    do_write(3'd4, 16'h0100, 1'b1, w);
    check("idle_wc_no_flush", filt_rst_n, 1);
    check("idle_wc_ready", cfg_if.cfg_ready, 1);
    do_commit();
    check_bank("pre_rst");
    tick();
    check("flush2_filt_rst_n", filt_rst_n, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    reset_seq("mid_flush_rst");

    // Shadow bank was cleared: only the new write appears after commit.
    do_write(3'd1, 16'h0001, 1'b0, w);
    do_commit();
    flush_seq("post_rst");

    check("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/iir_coef_ctrl.md
# iir_coef_ctrl

Coefficient-update and sequencing controller for the biquad IIR notch filter datapath. Owns the five 16-bit coefficients (B0, B1, B2, A1, A2) driven into the filter and buffers register-port writes in a shadow bank. On commit it applies all five at once, holds the filter in reset long enough to flush its x/y history, and gates sample validity until the pipeline has refilled. It sits between the configuration bus and the filter instance, and also drives the filter's active-low reset.

## Interface
- `COEF_W`, 16: coefficient width, signed Q2.14.
- `FLUSH_CYCLES`, 4: cycles the filter reset is held after a commit or a system reset (≥1).
- `PIPE_LAT`, 3: filter latency, data_in to data_out, in cycles (≥1).
- `clk` in 1: the only clock.
- `rst` in 1: synchronous, active-high reset.
- `cfg_valid` in 1: coefficient write request.
- `cfg_ready` out 1: write can be accepted.
- `cfg_addr` in 3: 0=B0, 1=B1, 2=B2, 3=A1, 4=A2; 5–7 are illegal.
- `cfg_data` in COEF_W: coefficient value.
- `cfg_commit` in 1: single-cycle pulse requesting the shadow-to-active transfer.
- `cfg_err` out 1: single-cycle pulse when a write uses an illegal address.
- `in_valid` in 1: a sample is presented to the filter this cycle.
- `out_valid` out 1: the filter's data_out is a valid sample.
- `busy` out 1: the controller is in FLUSH or SETTLE.
- `filt_rst_n` out 1: drives the filter's rst_n.
- `B0`, `B1`, `B2`, `A1`, `A2` out COEF_W each: active coefficients.

## Operation
- Reset state:
  - FSM is in FLUSH and the flush counter is 0.
  - Active and shadow banks hold B0=16384 (1.0) and all others 0, so the filter passes data through.
  - dirty=0, valid shift register cleared.
  - Outputs: `filt_rst_n`=0, `busy`=1, `out_valid`=0, `cfg_ready`=0, `cfg_err`=0.
- FSM states: IDLE, ARMED, FLUSH, SETTLE.
  - IDLE: shadow bank equals active bank. An accepted write moves to ARMED. `cfg_commit` is ignored.
  - ARMED: the shadow bank is dirty. Further writes are accepted. `cfg_commit` copies the shadow bank into the active bank on that clock edge, clears dirty, and moves to FLUSH.
  - FLUSH: `filt_rst_n`=0 for exactly FLUSH_CYCLES cycles, then the FSM moves to SETTLE.
  - SETTLE: `filt_rst_n`=1 for exactly PIPE_LAT cycles, then the FSM moves to IDLE.
- Handshake:
  - `cfg_ready`=1 only in IDLE and ARMED.
  - A write is accepted when `cfg_valid` && `cfg_ready`.
  - `cfg_valid` while `cfg_ready`=0 has no effect. The requester must hold the request until it is accepted.
- Illegal address: an accepted write with `cfg_addr`>4 leaves the banks unchanged and causes no state change. `cfg_err`=1 for the following cycle.
- Write and commit in the same ARMED cycle: the write lands in the shadow bank first, and the commit transfers the updated value.
- Write and commit in the same IDLE cycle: the write is accepted and the FSM goes to ARMED. The commit is ignored.
- Active coefficients change only on a commit edge. They never change during FLUSH or SETTLE.
- Validity tracking:
  - A PIPE_LAT-deep shift register carries `in_valid`. `out_valid` is its last stage.
  - The register is forced to 0 while `filt_rst_n`=0.
  - During SETTLE, samples enter the register normally. `out_valid` therefore reappears exactly PIPE_LAT cycles after the first post-flush `in_valid`.
- `rst` asserted in any state, including mid-flush or ARMED, returns the controller to the reset state on the next edge. Pending shadow writes are lost.

## Timing
- `rst` is sampled on the `clk` edge. Every output is registered; there are no combinational paths from input to output.
- Write latency: an accepted write at edge n is visible in the shadow bank after edge n. `cfg_err` is high in cycle n+1.
- Commit:
  - `cfg_commit` sampled at edge n puts the new active coefficients on the outputs and drives `filt_rst_n`=0 from cycle n+1.
  - `filt_rst_n` returns to 1 at cycle n+1+FLUSH_CYCLES.
  - The FSM reaches IDLE and `cfg_ready` returns to 1 at cycle n+1+FLUSH_CYCLES+PIPE_LAT.
- After `rst` is released: FLUSH_CYCLES of reset, then PIPE_LAT of SETTLE, so `cfg_ready`=1 at cycle FLUSH_CYCLES+PIPE_LAT.
- `busy` equals (state is FLUSH or SETTLE) and is registered alongside the state.

## Test plan
- Reset with defaults → `filt_rst_n`=0 for 4 cycles and `cfg_ready`=1 after 7 cycles. Coefficients read B0=16384, B1=B2=A1=A2=0. Continuous `in_valid` → `out_valid` high 3 cycles after the first post-flush sample.
- Write B0=0x3A00, B1=0x8C40, A1=0x7000, then commit → all three outputs update on the same edge, B2 and A2 unchanged. `filt_rst_n` low for exactly 4 cycles, `out_valid` low through the flush. `busy` high for 7 cycles.
- `cfg_valid` held during FLUSH/SETTLE with addr=2, data=0x1234 → stalls with `cfg_ready`=0. Accepted on the first IDLE cycle, then B2 reads 0x1234 after commit.
- Write addr=6, data=0x5555 → `cfg_err` pulses for 1 cycle. Banks and FSM unchanged; a subsequent commit in IDLE is ignored (no flush).
- Write A2=0xC000 and assert `cfg_commit` in the same ARMED cycle → A2 becomes 0xC000 on that commit and a flush follows.
- Assert `rst` on the 2nd flush cycle after a commit → FSM restarts FLUSH from 0. Coefficients return to defaults and the shadow bank is cleared.
